// File: rtl/sa_pkg.sv
// sa_pkg: constants and helpers shared by the systolic-array result drain.
//   SA_WIDTH / SA_HPE / SA_VPE : default operand width and array geometry
//   SA_N, SA_CNT_W, SA_ROW_W, SA_COL_W : derived sizes for those defaults
//   drain_state_e              : drain FSM state encoding
//   clog2_min1()               : $clog2 clamped to at least one bit
//   elem_offset()              : bit offset of element k inside the flat bus
package sa_pkg;

  localparam int SA_WIDTH = 32;
  localparam int SA_HPE   = 64;
  localparam int SA_VPE   = 64;

  localparam int SA_N     = SA_HPE * SA_VPE;
  localparam int SA_CNT_W = $clog2(SA_N);
  localparam int SA_ROW_W = $clog2(SA_VPE);
  localparam int SA_COL_W = $clog2(SA_HPE);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_e;

  // Keeps index fields at least one bit wide for degenerate 1-wide arrays.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Element 0 lives in the most significant slice of the flat bus, so the
  // offset counts down from the top as k grows.
  function automatic int elem_offset(input int k, input int n, input int ew);
    return (n - k - 1) * ew;
  endfunction

endpackage

// File: rtl/sa_drain_idx.sv
// sa_drain_idx: row/column/linear element counter for the result drain.
// The row and column are stepped incrementally so no divider is needed.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset (counters to zero)
//   clr_i  : restart at element 0 (wins over en_i)
//   en_i   : advance by one element; wraps to 0 after the last element
//   cnt_o  : linear element index (row-major)
//   row_o  : row of the current element
//   col_o  : column of the current element
//   last_o : current element is the final one of the frame
module sa_drain_idx #(
  parameter int HPE   = 2,
  parameter int VPE   = 2,
  parameter int CNT_W = 2,
  parameter int ROW_W = 1,
  parameter int COL_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             col_end;
  logic             row_end;

  assign col_end = (col_q == COL_W'(HPE - 1));
  assign row_end = (row_q == ROW_W'(VPE - 1));

  always_comb begin
    cnt_d = cnt_q;
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      cnt_d = '0;
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      cnt_d = (col_end && row_end) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = col_end && row_end;

endmodule

// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots the systolic array's flat accumulator bus on a
// START pulse and streams the results one element per beat, row-major.
//   CLK       : clock, rising edge
//   RST       : synchronous active-low reset
//   Y_IN      : flat result bus, element (0,0) in the MSB slice
//   START     : one-cycle "results complete, capture now" pulse
//   BUSY      : high while streaming a frame
//   OUT_VALID : element presented on OUT_DATA
//   OUT_READY : consumer accepts the presented element
//   OUT_DATA  : result element (zero while OUT_VALID is low)
//   OUT_ROW   : row index of the presented element
//   OUT_COL   : column index of the presented element
//   OUT_LAST  : presented element is the last of the frame
//   DONE      : one-cycle pulse after the final element is accepted
//   OVERRUN   : sticky; a START arrived mid-frame and was dropped
//   DBG_STATE : current FSM state (drain_state_e encoding)
//
// Handshake: a beat transfers on a rising edge where OUT_VALID && OUT_READY.
// Once OUT_VALID is raised it stays high, with OUT_DATA/ROW/COL/LAST held,
// until that beat transfers. OUT_READY only feeds register next-state logic,
// never an output.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter int  WIDTH = SA_WIDTH,
  parameter int  HPE   = SA_HPE,
  parameter int  VPE   = SA_VPE,
  localparam int N     = HPE * VPE,
  localparam int EW    = 2 * WIDTH,
  localparam int CNT_W = clog2_min1(N),
  localparam int ROW_W = clog2_min1(VPE),
  localparam int COL_W = clog2_min1(HPE)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [EW*N-1:0]   Y_IN,
  input  logic              START,
  output logic              BUSY,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [EW-1:0]     OUT_DATA,
  output logic [ROW_W-1:0]  OUT_ROW,
  output logic [COL_W-1:0]  OUT_COL,
  output logic              OUT_LAST,
  output logic              DONE,
  output logic              OVERRUN,
  output logic [0:0]        DBG_STATE
);

  localparam logic [0:0] S_IDLE   = ST_IDLE;
  localparam logic [0:0] S_STREAM = ST_STREAM;

  logic [0:0]       state_q, state_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic [EW-1:0]    buf_q [N];

  logic             streaming;
  logic             xfer;
  logic             final_xfer;
  logic             start_acc;
  logic [CNT_W-1:0] cnt;
  logic             idx_last;

  assign streaming  = (state_q == S_STREAM);
  assign xfer       = streaming && OUT_READY;
  assign final_xfer = xfer && idx_last;
  // A START is taken from IDLE, or in the very cycle the final beat leaves,
  // which lets back-to-back frames run without a bubble.
  assign start_acc  = START && (!streaming || final_xfer);

  sa_drain_idx #(
    .HPE   (HPE),
    .VPE   (VPE),
    .CNT_W (CNT_W),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_idx (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (start_acc),
    .en_i   (xfer),
    .cnt_o  (cnt),
    .row_o  (OUT_ROW),
    .col_o  (OUT_COL),
    .last_o (idx_last)
  );

  always_comb begin
    state_d   = state_q;
    done_d    = final_xfer;
    overrun_d = overrun_q;
    if (start_acc) begin
      state_d = S_STREAM;
    end else if (final_xfer) begin
      state_d = S_IDLE;
    end
    if (START && !start_acc) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Capture buffer is deliberately not reset; it is only read while
  // streaming, and every stream begins with a fresh capture.
  always_ff @(posedge CLK) begin
    if (RST && start_acc) begin
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= Y_IN[elem_offset(k, N, EW) +: EW];
      end
    end
  end

  assign BUSY      = streaming;
  assign OUT_VALID = streaming;
  assign OUT_DATA  = streaming ? buf_q[cnt] : '0;
  assign OUT_LAST  = streaming && idx_last;
  assign DONE      = done_q;
  assign OVERRUN   = overrun_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_sa_result_drain.sv
module tb_sa_result_drain;

  localparam int WIDTH = 8;
  localparam int HPE   = 2;
  localparam int VPE   = 2;
  localparam int N     = HPE * VPE;
  localparam int EW    = 2 * WIDTH;
  localparam int YW    = EW * N;

  localparam logic [YW-1:0] Y0 = 64'h0001_0002_0003_0004;
  localparam logic [YW-1:0] Y1 = 64'h0A0B_0C0D_0E0F_1011;
  localparam logic [YW-1:0] YF = {YW{1'b1}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [YW-1:0] y_in;
  logic          start;
  logic          out_ready;
  logic          busy;
  logic          out_valid;
  logic [EW-1:0] out_data;
  logic [0:0]    out_row;
  logic [0:0]    out_col;
  logic          out_last;
  logic          done;
  logic          overrun;
  logic [0:0]    dbg_state;

  sa_result_drain #(
    .WIDTH (WIDTH),
    .HPE   (HPE),
    .VPE   (VPE)
  ) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .Y_IN      (y_in),
    .START     (start),
    .BUSY      (busy),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
    .OUT_ROW   (out_row),
    .OUT_COL   (out_col),
    .OUT_LAST  (out_last),
    .DONE      (done),
    .OVERRUN   (overrun),
    .DBG_STATE (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {data[15:0], row, col, last}
  logic [EW+2:0] exp_q[$];
  logic          done_exp = 1'b0;
  logic          ovr_exp  = 1'b0;
  int            checks   = 0;
  int            errors   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic push_frame(input logic [YW-1:0] y);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back({y[(N-1-k)*EW +: EW], 1'(k / HPE), 1'(k % HPE), (k == N-1)});
    end
  endtask

  task automatic check_outputs(input string tag);
    logic          mv;
    logic [EW+2:0] e;
    mv = (exp_q.size() != 0);
    chk({tag, "_valid"}, 64'(out_valid), 64'(mv));
    chk({tag, "_busy"}, 64'(busy), 64'(mv));
    chk({tag, "_done"}, 64'(done), 64'(done_exp));
    chk({tag, "_overrun"}, 64'(overrun), 64'(ovr_exp));
    if (mv) begin
      e = exp_q[0];
      chk({tag, "_data"}, 64'(out_data), 64'(e[EW+2:3]));
      chk({tag, "_row"}, 64'(out_row), 64'(e[2]));
      chk({tag, "_col"}, 64'(out_col), 64'(e[1]));
      chk({tag, "_last"}, 64'(out_last), 64'(e[0]));
    end else begin
      chk({tag, "_data_idle"}, 64'(out_data), 64'd0);
      chk({tag, "_last_idle"}, 64'(out_last), 64'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives one cycle of inputs on the falling edge, advances the model for
  // the coming rising edge, then checks the outputs just after that edge.
  task automatic cycle(input logic rdy, input logic st, input logic [YW-1:0] y, input string tag);
    logic mv, xfer, lastx;
    @(negedge clk);
    out_ready = rdy;
    start     = st;
    y_in      = y;
    mv    = (exp_q.size() != 0);
    xfer  = mv && rdy;
    lastx = xfer && exp_q[0][0];
    if (xfer) void'(exp_q.pop_front());
    if (st) begin
      if (!mv || lastx) push_frame(y);
      else ovr_exp = 1'b1;
    end
    done_exp = lastx;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    done_exp = 1'b0;
    ovr_exp  = 1'b0;
    check_outputs(tag);
    chk({tag, "_row"}, 64'(out_row), 64'd0);
    chk({tag, "_col"}, 64'(out_col), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          st;
    logic          rdy;
    logic [YW-1:0] y;
    logic          v;
    logic [EW-1:0] d;
    logic          r;
    logic          c;
    logic          l;
    logic          dn;
  } vec_t;

  vec_t tbl[6];

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    y_in      = '0;

    do_reset("reset");

    // Basic stream, expectations written out by hand.
    tbl[0] = '{st:1'b1, rdy:1'b1, y:Y0, v:1'b1, d:16'h0001, r:1'b0, c:1'b0, l:1'b0, dn:1'b0};
    tbl[1] = '{st:1'b0, rdy:1'b1, y:Y0, v:1'b1, d:16'h0002, r:1'b0, c:1'b1, l:1'b0, dn:1'b0};
    tbl[2] = '{st:1'b0, rdy:1'b1, y:Y0, v:1'b1, d:16'h0003, r:1'b1, c:1'b0, l:1'b0, dn:1'b0};
    tbl[3] = '{st:1'b0, rdy:1'b1, y:Y0, v:1'b1, d:16'h0004, r:1'b1, c:1'b1, l:1'b1, dn:1'b0};
    tbl[4] = '{st:1'b0, rdy:1'b1, y:Y0, v:1'b0, d:16'h0000, r:1'b0, c:1'b0, l:1'b0, dn:1'b1};
    tbl[5] = '{st:1'b0, rdy:1'b1, y:Y0, v:1'b0, d:16'h0000, r:1'b0, c:1'b0, l:1'b0, dn:1'b0};
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].rdy, tbl[i].st, tbl[i].y, $sformatf("basic%0d", i));
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].v));
      chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].d));
      chk($sformatf("tbl%0d_last", i), 64'(out_last), 64'(tbl[i].l));
      chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].dn));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_row", i), 64'(out_row), 64'(tbl[i].r));
        chk($sformatf("tbl%0d_col", i), 64'(out_col), 64'(tbl[i].c));
      end
    end

    // Backpressure: ready pattern 1,0,0,1 repeating.
    cycle(1'b0, 1'b1, Y1, "bp_start");
    for (int i = 0; i < 14; i++) begin
      cycle((i % 4 == 0) || (i % 4 == 3), 1'b0, Y1, "bp");
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, Y1, "bp_drain");

    // Capture isolation: bus goes all-ones right after the start.
    cycle(1'b1, 1'b1, Y0, "iso_start");
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, YF, "iso");

    // Overrun: second START while the 2nd beat is presented.
    cycle(1'b1, 1'b1, Y0, "ovr_start");
    cycle(1'b1, 1'b0, Y0, "ovr_beat1");
    cycle(1'b1, 1'b1, Y1, "ovr_hit");
    chk("ovr_sticky_set", 64'(overrun), 64'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, Y1, "ovr_drain");
    chk("ovr_sticky_hold", 64'(overrun), 64'd1);

    // Back-to-back: START in the final-transfer cycle.
    cycle(1'b1, 1'b1, Y0, "b2b_start");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, Y0, "b2b");
    cycle(1'b1, 1'b1, Y1, "b2b_last");
    chk("b2b_done", 64'(done), 64'd1);
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_next", 64'(out_data), 64'h0A0B);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, Y1, "b2b_drain");

    // Reset mid-frame, then a clean restart.
    cycle(1'b1, 1'b1, Y0, "rst_start");
    cycle(1'b1, 1'b0, Y0, "rst_beat1");
    do_reset("rst_mid");
    cycle(1'b1, 1'b0, Y0, "rst_idle");
    cycle(1'b1, 1'b1, Y1, "rst_restart");
    chk("rst_restart_first", 64'(out_data), 64'h0A0B);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, Y1, "rst_drain");

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
            {$urandom, $urandom}, "rand");
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, "rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sa_result_drain.md
# sa_result_drain

Result-side drain for the `sa_2D` systolic array. On a `START` pulse it snapshots the array's flat accumulator bus, then streams the results one element per beat over a valid/ready interface, in row-major order. It sits between `sa_2D` and the downstream consumer (writeback/DMA), so the array can begin its next computation while the previous results drain.

## Interface
- `WIDTH`, 32, operand width; each result element is `2*WIDTH` bits.
- `HPE`, 64, PEs per row (columns).
- `VPE`, 64, PE rows.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, synchronous and active-low.
- `Y_IN` in `2*WIDTH*HPE*VPE`: flat result bus from `sa_2D`.
- `START` in 1: one-cycle pulse meaning "results complete, capture now".
- `BUSY` out 1: high while in STREAM.
- `OUT_VALID` out 1: an element is presented on `OUT_DATA`.
- `OUT_READY` in 1: the consumer accepts the presented element.
- `OUT_DATA` out `2*WIDTH`: result element.
- `OUT_ROW` out `$clog2(VPE)`: row index of the current element.
- `OUT_COL` out `$clog2(HPE)`: column index of the current element.
- `OUT_LAST` out 1: current element is the final one (k = N-1).
- `DONE` out 1: one-cycle pulse after the final element is accepted.
- `OVERRUN` out 1: sticky error; a `START` was dropped.

## Operation
- Definitions:
  - N = HPE*VPE.
  - Element k = r*HPE + c, with row r in 0..VPE-1 and column c in 0..HPE-1.
  - Element k occupies `Y_IN[(N-k)*2*WIDTH-1 : (N-k-1)*2*WIDTH]`, so element (0,0) is the MSB slice.
- Storage:
  - N-entry capture buffer, each entry `2*WIDTH` wide.
  - Element counter `cnt`, `$clog2(N)` bits.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - `OUT_VALID`=0 and `BUSY`=0.
  - `START`=1 captures all of `Y_IN` into the buffer, sets `cnt`=0, and moves to STREAM.
- STREAM:
  - `OUT_VALID`=1 and `BUSY`=1.
  - `OUT_DATA` = buffer[cnt]; `OUT_ROW` = cnt / HPE; `OUT_COL` = cnt % HPE.
  - `OUT_LAST` = (cnt == N-1).
- Handshake:
  - A beat transfers when `OUT_VALID` && `OUT_READY` at a rising edge; `cnt` then increments.
  - While `OUT_VALID`=1 and `OUT_READY`=0, `OUT_DATA`, `OUT_ROW`, `OUT_COL` and `OUT_LAST` hold stable.
  - `OUT_VALID` never drops until the beat transfers.
- Final beat: a transfer with `cnt`=N-1 returns the FSM to IDLE, pulses `DONE` in the next cycle, and resets `cnt` to 0.
- `START` in the same cycle as the final transfer:
  - The start is accepted: new capture, `cnt`=0, FSM stays in STREAM.
  - `DONE` still pulses for the completed frame.
- `START` in STREAM at any other time:
  - Ignored; the buffer is not overwritten.
  - `OVERRUN` is set and stays high until reset.
- `OUT_DATA` reads 0 whenever `OUT_VALID`=0.
- No arithmetic is performed on the data; it passes through bit-exact.

## Timing
- Reset values: state IDLE, `cnt`=0, and `BUSY`, `OUT_VALID`, `OUT_LAST`, `DONE`, `OVERRUN`, `OUT_DATA`, `OUT_ROW`, `OUT_COL` all 0. The buffer is not cleared.
- Reset mid-STREAM:
  - Aborts the frame with no `DONE`.
  - `OUT_VALID` is 0 in the cycle after the reset edge.
- Latency: with `START` sampled at edge t, `OUT_VALID`=1 with element 0 after edge t.
- `Y_IN` is sampled only at edge t; later changes on it do not affect the frame.
- Throughput: one element per cycle with `OUT_READY` held high, so a frame takes N cycles.
- `DONE` is high for exactly the cycle after the final transfer edge.
- No combinational path from `OUT_READY` to any output. All outputs come from registers or from a buffer mux indexed by a register.

## Structure
- Shared package `sa_pkg` holds:
  - defaults for `WIDTH`, `HPE`, `VPE`;
  - derived constants N, `CNT_W` = `$clog2(N)`, `ROW_W`, `COL_W`;
  - a state enum {IDLE, STREAM};
  - a function returning the bit offset of element k.
- Sub-module `sa_drain_idx`: a row/column counter with enable, clear and last flag, keeping `OUT_ROW`/`OUT_COL` incremental (no divider).

## Test plan
Bench parameters: `WIDTH`=8, `HPE`=`VPE`=2, so N=4 with 16-bit elements.
- Basic stream: `Y_IN`=64'h0001_0002_0003_0004, `START` pulse, `OUT_READY`=1 -> `OUT_DATA` 0001, 0002, 0003, 0004 on 4 consecutive cycles, with (row,col) = (0,0), (0,1), (1,0), (1,1). `OUT_LAST` is high only on 0004; `DONE` pulses once on the following cycle.
- Backpressure: `OUT_READY` toggling 1,0,0,1,… -> every element delivered exactly once, in order, with `OUT_DATA` stable during stalls.
- Capture isolation: change `Y_IN` to all-FF one cycle after `START` -> the original 0001..0004 are streamed.
- Overrun: `START` during the 2nd beat -> `OVERRUN`=1, the current frame is unchanged, and no restart occurs.
- Back-to-back: `START` with new `Y_IN`=64'h0A0B_0C0D_0E0F_1011 in the final-transfer cycle -> `DONE` pulses, `OUT_VALID` stays high, and the next element is 0A0B.
- Reset mid-frame: `RST`=0 after beat 1 -> the next cycle has `OUT_VALID`=0, `BUSY`=0, and no `DONE`; a later `START` streams correctly from element 0.
